// File: rtl/inference_self_test.sv
`timescale 1ns/1ps
// Golden-vector self test: streams each reference image into the inference engine's image RAM,
// starts it, then compares its scores and prediction against the golden ROMs and keeps statistics.
module inference_self_test #(
  parameter int NUM_TESTS      = 100,
  parameter int IMAGE_SIZE     = 784,
  parameter int NUM_CLASSES    = 10,
  parameter int SCORE_W        = 32,
  parameter int TOL            = 0,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int PIX_AW = (NUM_TESTS * IMAGE_SIZE > 1) ? $clog2(NUM_TESTS * IMAGE_SIZE) : 1,
  localparam int IMG_AW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
  localparam int GS_AW  = (NUM_TESTS * NUM_CLASSES > 1) ? $clog2(NUM_TESTS * NUM_CLASSES) : 1,
  localparam int TI_W   = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           go,
  output logic                           busy,
  output logic                           finished,
  output logic [PIX_AW-1:0]              gpix_addr,
  input  logic [7:0]                     gpix_data,
  output logic                           img_wr_en,
  output logic [IMG_AW-1:0]              img_wr_addr,
  output logic [7:0]                     img_wr_data,
  output logic [GS_AW-1:0]               gscore_addr,
  input  logic [SCORE_W-1:0]             gscore_data,
  input  logic [3:0]                     gpred_data,
  output logic [TI_W-1:0]                test_idx,
  output logic                           dut_start,
  input  logic                           dut_done,
  input  logic [3:0]                     dut_pred,
  input  logic [NUM_CLASSES*SCORE_W-1:0] dut_scores,
  output logic [15:0]                    pass_count,
  output logic [15:0]                    fail_count,
  output logic [15:0]                    pred_ok_count,
  output logic [SCORE_W-1:0]             max_abs_diff,
  output logic [15:0]                    first_fail_idx,
  output logic                           timeout_flag
);

  localparam int CLS_W         = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int TMR_W0        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMR_W         = (TMR_W0 > 4) ? TMR_W0 : 4;
  localparam int SETTLE_CYCLES = 10;

  localparam logic [IMG_AW-1:0]  IMG_LAST     = IMG_AW'(IMAGE_SIZE - 1);
  localparam logic [CLS_W-1:0]   CLS_LAST     = CLS_W'(NUM_CLASSES - 1);
  localparam logic [TI_W-1:0]    TEST_LAST    = TI_W'(NUM_TESTS - 1);
  localparam logic [TMR_W-1:0]   SETTLE_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SCORE_W:0]   TOL_V        = (SCORE_W + 1)'(TOL);

  // FSM: IDLE -> LOAD (copy image) -> SETTLE -> START -> WAIT -> CHECK (per class) -> NEXT -> DONE
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_START, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t                           state_q;
  logic [TMR_W-1:0]                 tmr_q;
  logic [CLS_W-1:0]                 cls_q;
  logic [NUM_CLASSES*SCORE_W-1:0]   scores_q;
  logic [3:0]                       pred_q;
  logic                             mism_q;

  logic [SCORE_W-1:0]               cap_score_d;
  logic signed [SCORE_W:0]          delta_d;
  logic [SCORE_W:0]                 diff_d;
  logic [SCORE_W-1:0]               diff_sat_d;
  logic                             mism_d;

  assign img_wr_data = gpix_data;

  // One extra bit keeps the full signed range difference exact.
  always_comb begin
    cap_score_d = scores_q[cls_q*SCORE_W +: SCORE_W];
    delta_d     = $signed({cap_score_d[SCORE_W-1], cap_score_d})
                - $signed({gscore_data[SCORE_W-1], gscore_data});
    diff_d      = delta_d[SCORE_W] ? $unsigned(-delta_d) : $unsigned(delta_d);
    diff_sat_d  = diff_d[SCORE_W] ? '1 : diff_d[SCORE_W-1:0];
    mism_d      = diff_d > TOL_V;
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tmr_q          <= '0;
      cls_q          <= '0;
      scores_q       <= '0;
      pred_q         <= '0;
      mism_q         <= 1'b0;
      busy           <= 1'b0;
      finished       <= 1'b0;
      gpix_addr      <= '0;
      img_wr_en      <= 1'b0;
      img_wr_addr    <= '0;
      gscore_addr    <= '0;
      test_idx       <= '0;
      dut_start      <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      pred_ok_count  <= '0;
      max_abs_diff   <= '0;
      first_fail_idx <= 16'hFFFF;
      timeout_flag   <= 1'b0;
    end else begin
      img_wr_en <= 1'b0;
      dut_start <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            pass_count     <= '0;
            fail_count     <= '0;
            pred_ok_count  <= '0;
            max_abs_diff   <= '0;
            first_fail_idx <= 16'hFFFF;
            timeout_flag   <= 1'b0;
            finished       <= 1'b0;
            busy           <= 1'b1;
            test_idx       <= '0;
            gpix_addr      <= '0;
            img_wr_addr    <= '0;
            img_wr_en      <= 1'b1;
            state_q        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (img_wr_addr == IMG_LAST) begin
            tmr_q   <= SETTLE_LOAD;
            state_q <= S_SETTLE;
          end else begin
            img_wr_en   <= 1'b1;
            img_wr_addr <= img_wr_addr + 1'b1;
            gpix_addr   <= gpix_addr + 1'b1;
          end
        end
        S_SETTLE: begin
          if (tmr_q == '0) begin
            dut_start <= 1'b1;
            state_q   <= S_START;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_START: begin
          tmr_q   <= TIMEOUT_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (dut_done) begin
            scores_q    <= dut_scores;
            pred_q      <= dut_pred;
            cls_q       <= '0;
            mism_q      <= 1'b0;
            gscore_addr <= GS_AW'(test_idx * NUM_CLASSES);
            state_q     <= S_CHECK;
          end else if (tmr_q == '0) begin
            timeout_flag <= 1'b1;
            busy         <= 1'b0;
            finished     <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_CHECK: begin
          if (mism_d) mism_q <= 1'b1;
          if (diff_sat_d > max_abs_diff) max_abs_diff <= diff_sat_d;
          if (cls_q == CLS_LAST) begin
            state_q <= S_NEXT;
          end else begin
            cls_q       <= cls_q + 1'b1;
            gscore_addr <= gscore_addr + 1'b1;
          end
        end
        S_NEXT: begin
          if (mism_q) begin
            fail_count <= sat_inc(fail_count);
            if (first_fail_idx == 16'hFFFF) first_fail_idx <= 16'(test_idx);
          end else begin
            pass_count <= sat_inc(pass_count);
          end
          if (pred_q == gpred_data) pred_ok_count <= sat_inc(pred_ok_count);
          if (test_idx == TEST_LAST) begin
            busy     <= 1'b0;
            finished <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            // gpix_addr still holds the previous image's last pixel, so +1 is the next image base.
            test_idx    <= test_idx + 1'b1;
            gpix_addr   <= gpix_addr + 1'b1;
            img_wr_addr <= '0;
            img_wr_en   <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inference_self_test.sv
`timescale 1ns/1ps
// Two self-test instances (exact compare with short timeout, and TOL=5) against an echoing
// inference model; expected pass statistics are queued at each go and checked at finish.
module tb_inference_self_test;

  localparam int NT = 2, IS = 4, NC = 10, SW = 32;
  localparam int TO_A = 50, TO_B = 1000;
  localparam int TOL_A = 0, TOL_B = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] go, busy, finished, img_wr_en, dut_start, timeout_flag;
  logic [2:0]       gpix_addr     [2];
  logic [7:0]       gpix_data     [2];
  logic [1:0]       img_wr_addr   [2];
  logic [7:0]       img_wr_data   [2];
  logic [4:0]       gscore_addr   [2];
  logic [31:0]      gscore_data   [2];
  logic [3:0]       gpred_data    [2];
  logic [0:0]       test_idx      [2];
  logic             dut_done      [2];
  logic [3:0]       dut_pred      [2];
  logic [NC*SW-1:0] dut_scores    [2];
  logic [15:0]      pass_count    [2];
  logic [15:0]      fail_count    [2];
  logic [15:0]      pred_ok_count [2];
  logic [31:0]      max_abs_diff  [2];
  logic [15:0]      first_fail_idx[2];

  logic [7:0]  gpix   [NT*IS];
  logic [31:0] gscore [32];
  logic [3:0]  gpred  [NT];
  logic [31:0] dscore [NT*NC];
  logic [3:0]  dpred  [NT];
  bit hang, stray;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign gpix_data[g]   = gpix[gpix_addr[g]];
    assign gscore_data[g] = gscore[gscore_addr[g]];
    assign gpred_data[g]  = gpred[test_idx[g]];
    inference_self_test #(
      .NUM_TESTS(NT), .IMAGE_SIZE(IS), .NUM_CLASSES(NC), .SCORE_W(SW),
      .TOL(g == 0 ? TOL_A : TOL_B), .TIMEOUT_CYCLES(g == 0 ? TO_A : TO_B)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .go(go[g]), .busy(busy[g]), .finished(finished[g]),
      .gpix_addr(gpix_addr[g]), .gpix_data(gpix_data[g]), .img_wr_en(img_wr_en[g]),
      .img_wr_addr(img_wr_addr[g]), .img_wr_data(img_wr_data[g]),
      .gscore_addr(gscore_addr[g]), .gscore_data(gscore_data[g]), .gpred_data(gpred_data[g]),
      .test_idx(test_idx[g]), .dut_start(dut_start[g]), .dut_done(dut_done[g]),
      .dut_pred(dut_pred[g]), .dut_scores(dut_scores[g]),
      .pass_count(pass_count[g]), .fail_count(fail_count[g]), .pred_ok_count(pred_ok_count[g]),
      .max_abs_diff(max_abs_diff[g]), .first_fail_idx(first_fail_idx[g]),
      .timeout_flag(timeout_flag[g])
    );
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int pass_c; int fail_c; int pok; int ffi; int nstart; longint maxd; bit tmo;
  } exp_t;
  typedef struct { int t; int a; logic [7:0] d; } wr_t;

  exp_t q0[$];
  exp_t q1[$];
  wr_t  wq[$];

  // Reference: per test, any class with |dut-golden| > tol fails it; pred compared separately.
  function automatic exp_t model(input int tol, input bit hang_m);
    exp_t e;
    e.pass_c = 0; e.fail_c = 0; e.pok = 0; e.ffi = 65535; e.maxd = 0; e.tmo = 0; e.nstart = NT;
    if (hang_m) begin
      e.tmo = 1; e.nstart = 1;
      return e;
    end
    for (int t = 0; t < NT; t++) begin
      bit bad = 0;
      for (int k = 0; k < NC; k++) begin
        longint d = longint'($signed(dscore[t*NC+k])) - longint'($signed(gscore[t*NC+k]));
        if (d < 0) d = -d;
        if (d > tol) bad = 1;
        if (d > e.maxd) e.maxd = d;
      end
      if (bad) begin
        e.fail_c++;
        if (e.ffi == 65535) e.ffi = t;
      end else begin
        e.pass_c++;
      end
      if (dpred[t] == gpred[t]) e.pok++;
    end
    return e;
  endfunction

  task automatic push_writes(input int ntests);
    wr_t w;
    for (int t = 0; t < ntests; t++)
      for (int i = 0; i < IS; i++) begin
        w.t = t; w.a = i; w.d = gpix[t*IS+i];
        wq.push_back(w);
      end
  endtask

  task automatic new_data();
    for (int i = 0; i < NT*IS; i++) gpix[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) gscore[i] = $urandom;
    for (int t = 0; t < NT; t++) gpred[t] = 4'($urandom_range(9));
    for (int i = 0; i < NT*NC; i++) dscore[i] = gscore[i];
    for (int t = 0; t < NT; t++) dpred[t] = gpred[t];
  endtask

  // Inference engine model: echoes dscore/dpred 20 cycles after dut_start.
  int rcnt[2];
  int rt[2];
  initial begin
    for (int g = 0; g < 2; g++) begin
      dut_done[g] = 1'b0; dut_pred[g] = '0; dut_scores[g] = '0; rcnt[g] = 0; rt[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        dut_done[g] = 1'b0;
        if (!rst_n) begin
          rcnt[g] = 0;
        end else if (dut_start[g]) begin
          rcnt[g] = 20;
          rt[g] = int'(test_idx[g]);
        end else if (rcnt[g] > 0) begin
          rcnt[g]--;
          if (rcnt[g] == 0 && !hang) begin
            dut_done[g] = 1'b1;
            dut_pred[g] = dpred[rt[g]];
            for (int k = 0; k < NC; k++) dut_scores[g][k*SW +: SW] = dscore[rt[g]*NC+k];
          end
        end else if (stray && img_wr_en[g]) begin
          dut_done[g] = 1'b1;
          dut_pred[g] = 4'($urandom);
          for (int k = 0; k < NC; k++) dut_scores[g][k*SW +: SW] = $urandom;
        end
      end
    end
  end

  bit   prev_fin[2];
  bit   prev_st[2];
  int   start_cnt[2];
  int   start_w;
  exp_t mon_e;
  wr_t  mon_w;
  bit   mon_has;

  task automatic cmp_finish(input int g, input exp_t e);
    chk($sformatf("pass_count[%0d]", g), pass_count[g], e.pass_c);
    chk($sformatf("fail_count[%0d]", g), fail_count[g], e.fail_c);
    chk($sformatf("pred_ok[%0d]", g), pred_ok_count[g], e.pok);
    chk($sformatf("first_fail[%0d]", g), first_fail_idx[g], e.ffi);
    chk($sformatf("max_abs_diff[%0d]", g), max_abs_diff[g], e.maxd);
    chk($sformatf("timeout_flag[%0d]", g), timeout_flag[g], e.tmo);
    chk($sformatf("busy_at_end[%0d]", g), busy[g], 0);
    chk($sformatf("start_pulses[%0d]", g), start_cnt[g], e.nstart);
  endtask

  // Monitor: image writes of instance 0, start pulse shape, and end-of-pass statistics.
  initial begin
    start_w = 0;
    for (int g = 0; g < 2; g++) begin prev_fin[g] = 0; prev_st[g] = 0; start_cnt[g] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        start_w = 0;
        for (int g = 0; g < 2; g++) begin prev_fin[g] = 0; prev_st[g] = 0; start_cnt[g] = 0; end
      end else begin
        if (img_wr_en[0]) begin
          if (wq.size() == 0) begin
            chk("wr_unexpected", 1, 0);
          end else begin
            mon_w = wq.pop_front();
            chk("wr_test_idx", test_idx[0], mon_w.t);
            chk("wr_addr", img_wr_addr[0], mon_w.a);
            chk("wr_data", img_wr_data[0], mon_w.d);
            chk("gpix_addr", gpix_addr[0], mon_w.t*IS + mon_w.a);
          end
        end
        if (dut_start[0]) start_w++;
        else if (start_w > 0) begin
          chk("start_width", start_w, 1);
          start_w = 0;
        end
        for (int g = 0; g < 2; g++) begin
          if (dut_start[g] && !prev_st[g]) start_cnt[g]++;
          prev_st[g] = dut_start[g];
          if (finished[g] && !prev_fin[g]) begin
            mon_has = 0;
            if (g == 0 && q0.size() > 0) begin mon_e = q0.pop_front(); mon_has = 1; end
            if (g == 1 && q1.size() > 0) begin mon_e = q1.pop_front(); mon_has = 1; end
            chk($sformatf("finish_expected[%0d]", g), mon_has, 1);
            if (mon_has) cmp_finish(g, mon_e);
            if (g == 0) chk("wr_left", wq.size(), 0);
            start_cnt[g] = 0;
          end
          prev_fin[g] = finished[g];
        end
      end
    end
  end

  task automatic chk_reset(input int g, input string tag);
    chk($sformatf("%s_busy[%0d]", tag, g), busy[g], 0);
    chk($sformatf("%s_finished[%0d]", tag, g), finished[g], 0);
    chk($sformatf("%s_wr_en[%0d]", tag, g), img_wr_en[g], 0);
    chk($sformatf("%s_start[%0d]", tag, g), dut_start[g], 0);
    chk($sformatf("%s_tmo[%0d]", tag, g), timeout_flag[g], 0);
    chk($sformatf("%s_pass[%0d]", tag, g), pass_count[g], 0);
    chk($sformatf("%s_fail[%0d]", tag, g), fail_count[g], 0);
    chk($sformatf("%s_pok[%0d]", tag, g), pred_ok_count[g], 0);
    chk($sformatf("%s_max[%0d]", tag, g), max_abs_diff[g], 0);
    chk($sformatf("%s_ffi[%0d]", tag, g), first_fail_idx[g], 16'hFFFF);
    chk($sformatf("%s_idx[%0d]", tag, g), test_idx[g], 0);
    chk($sformatf("%s_gpix[%0d]", tag, g), gpix_addr[g], 0);
    chk($sformatf("%s_gscore[%0d]", tag, g), gscore_addr[g], 0);
    chk($sformatf("%s_wraddr[%0d]", tag, g), img_wr_addr[g], 0);
  endtask

  task automatic run_pass(input logic [1:0] mask, input bit mid_go);
    if (mask[0]) begin q0.push_back(model(TOL_A, 0)); push_writes(NT); end
    if (mask[1]) q1.push_back(model(TOL_B, 0));
    @(negedge clk); go = mask;
    @(negedge clk); go = 2'b00;
    if (mid_go) begin
      repeat (30) @(negedge clk);
      chk("busy_before_midgo", busy[0], 1);
      go = mask;
      @(negedge clk); go = 2'b00;
      chk("busy_after_midgo", busy[0], 1);
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ((finished & mask) == mask) break;
    end
    chk("pass_done", finished & mask, mask);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    rst_n = 1'b0; go = 2'b00; hang = 0; stray = 0;
    new_data();
    repeat (3) @(negedge clk);
    chk_reset(0, "por");
    chk_reset(1, "por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exact echo.
    run_pass(2'b11, 0);

    // Test 1 class 3 off by +5.
    new_data();
    gscore[13] = 32'(int'($urandom_range(2000)) - 1000);
    dscore[13] = gscore[13] + 32'd5;
    run_pass(2'b11, 0);
    chk("tol0_pass", pass_count[0], 1);
    chk("tol0_fail", fail_count[0], 1);
    chk("tol0_ffi", first_fail_idx[0], 1);
    chk("tol0_max", max_abs_diff[0], 5);
    chk("tol5_pass", pass_count[1], 2);

    // Full-range difference.
    new_data();
    gscore[0] = 32'h8000_0000;
    dscore[0] = 32'h7FFF_FFFF;
    run_pass(2'b11, 0);
    chk("extreme_max", max_abs_diff[0], 64'hFFFF_FFFF);
    chk("extreme_fail", fail_count[0], 1);

    // Random perturbations, stray done pulses, go while busy.
    for (int r = 0; r < 4; r++) begin
      new_data();
      for (int i = 0; i < NT*NC; i++)
        if ($urandom_range(3) == 0) dscore[i] = gscore[i] + 32'(int'($urandom_range(12)) - 6);
      for (int t = 0; t < NT; t++)
        if ($urandom_range(2) == 0) dpred[t] = 4'($urandom_range(9));
      stray = r[0];
      run_pass(2'b11, r == 1);
    end
    stray = 0;

    // Timeout: engine never answers.
    hang = 1;
    q0.push_back(model(TOL_A, 1));
    push_writes(1);
    @(negedge clk); go = 2'b01;
    @(negedge clk); go = 2'b00;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (dut_start[0]) begin found = 1; break; end
    end
    chk("tmo_start_seen", found, 1);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n++;
      if (timeout_flag[0]) break;
    end
    chk("tmo_latency", n, TO_A + 1);
    chk("tmo_finished", finished[0], 1);
    chk("tmo_pass", pass_count[0], 0);
    repeat (3) @(negedge clk);
    hang = 0;

    // Reset while checking test 1, then rerun from test 0.
    new_data();
    dscore[5] = gscore[5] + 32'd1;
    q0.push_back(model(TOL_A, 0));
    push_writes(NT);
    @(negedge clk); go = 2'b01;
    @(negedge clk); go = 2'b00;
    found = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (test_idx[0] == 1'b1 && gscore_addr[0] == 5'(NC + 2)) begin found = 1; break; end
    end
    chk("rst_point_found", found, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset(0, "midrst");
    q0.delete();
    wq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_pass(2'b01, 0);
    chk("rerun_fail", fail_count[0], 1);
    chk("rerun_ffi", first_fail_idx[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
